// File: rtl/alu_operand_stage.sv
// ALU operand-select stage: writeback bypass, mode mux and a
// one-deep valid/ready register holding the selected operand pair.
module alu_operand_stage #(
    parameter int WIDTH   = 8,
    parameter int IMM_W   = 5,
    parameter int RADDR_W = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         mode,
    input  logic [RADDR_W-1:0] src1_addr,
    input  logic [RADDR_W-1:0] src2_addr,
    input  logic [WIDTH-1:0]   operand1,
    input  logic [WIDTH-1:0]   operand2,
    input  logic [IMM_W-1:0]   immediate,
    input  logic               wb_valid,
    input  logic [RADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]   wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   alu_op1,
    output logic [WIDTH-1:0]   alu_op2,
    output logic [1:0]         fwd_hit
);

    typedef enum logic [1:0] {
        MODE_REG  = 2'b00,
        MODE_ZX   = 2'b01,
        MODE_SX   = 2'b10,
        MODE_SWAP = 2'b11
    } mode_e;

    logic               held_valid;
    logic [RADDR_W-1:0] held_addr;
    logic [WIDTH-1:0]   held_data;

    logic [WIDTH-1:0] byp1;
    logic [WIDTH-1:0] byp2;
    logic             hit1;
    logic             hit2;
    logic [WIDTH-1:0] imm_zx;
    logic [WIDTH-1:0] imm_sx;
    logic [WIDTH-1:0] sel1;
    logic [WIDTH-1:0] sel2;
    logic [1:0]       sel_hit;
    logic             accept;

    // Casts collapse to a plain copy when IMM_W == WIDTH.
    assign imm_zx = WIDTH'(immediate);
    assign imm_sx = WIDTH'($signed(immediate));

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Bypass each source; the live writeback wins over the held one.
    always_comb begin
        byp1 = operand1;
        hit1 = 1'b0;
        byp2 = operand2;
        hit2 = 1'b0;
        if (wb_valid && wb_addr == src1_addr) begin
            byp1 = wb_data;
            hit1 = 1'b1;
        end else if (held_valid && held_addr == src1_addr) begin
            byp1 = held_data;
            hit1 = 1'b1;
        end
        if (wb_valid && wb_addr == src2_addr) begin
            byp2 = wb_data;
            hit2 = 1'b1;
        end else if (held_valid && held_addr == src2_addr) begin
            byp2 = held_data;
            hit2 = 1'b1;
        end
    end

    // Pick the operand pair and matching bypass flags by mode.
    always_comb begin
        sel1    = byp1;
        sel2    = byp2;
        sel_hit = {hit2, hit1};
        unique case (mode)
            MODE_REG: begin
                sel1    = byp1;
                sel2    = byp2;
                sel_hit = {hit2, hit1};
            end
            MODE_ZX: begin
                sel2    = imm_zx;
                sel_hit = {1'b0, hit1};
            end
            MODE_SX: begin
                sel2    = imm_sx;
                sel_hit = {1'b0, hit1};
            end
            MODE_SWAP: begin
                sel1    = byp2;
                sel2    = byp1;
                sel_hit = {hit1, hit2};
            end
        endcase
    end

    // Keep last cycle's writeback to cover register-file write latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held_valid <= 1'b0;
            held_addr  <= '0;
            held_data  <= '0;
        end else begin
            held_valid <= wb_valid;
            held_addr  <= wb_addr;
            held_data  <= wb_data;
        end
    end

    // Output register: load on accept, drop valid on drain, else hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            alu_op1   <= '0;
            alu_op2   <= '0;
            fwd_hit   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            alu_op1   <= sel1;
            alu_op2   <= sel2;
            fwd_hit   <= sel_hit;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
